// File: rtl/bicubic_pkg.sv
// Shared types and widths for the 2-lane SIMD DSP chain controller.
// No logic; constants only.
// Used by dsp_simd2x_chain_ctrl and dsp_lane_unpack.
package bicubic_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int LANE_W   = 18;
    localparam int PIX_W    = 8;
    localparam int COEFF_W  = 9;
    localparam int LANE_OFS = 18;
    localparam int PIX_MAX  = (1 << PIX_W) - 1;

    // One tap of a pixel-pair word as presented to a DSP stage.
    typedef struct packed {
        logic signed [COEFF_W-1:0] coeff;
        logic [PIX_W-1:0]          pix_b;
        logic [PIX_W-1:0]          pix_a;
    } tap_t;

endpackage

// File: rtl/dsp_lane_unpack.sv
// Splits the packed two-lane DSP P word into signed lanes (BICUBIC_OUT_ROUND_SAT_EN adds round/saturate).
// Latency: combinational by default; one clken-qualified register stage when rounding is enabled.
// Backpressure: none of its own; the optional register holds while clken is low.
module dsp_lane_unpack
    import bicubic_pkg::*;
#(
    parameter int COEFF_FRAC = 7
) (
`ifdef BICUBIC_OUT_ROUND_SAT_EN
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     clken,
`endif
    input  logic [2*LANE_W-1:0]      p,
    output logic signed [LANE_W-1:0] res_a,
    output logic signed [LANE_W-1:0] res_b
);

    logic signed [LANE_W-1:0] raw_a;
    logic signed [LANE_W-1:0] raw_b;

    // A negative lane A borrows one from lane B inside the shared accumulator;
    // adding back lane A's sign bit restores lane B's true value.
    always_comb begin
        raw_a = p[LANE_W-1:0];
        raw_b = p[LANE_OFS +: LANE_W] + LANE_W'(p[LANE_W-1]);
    end

`ifdef BICUBIC_OUT_ROUND_SAT_EN
    // Round half-up at the coefficient binary point, then clamp to a pixel.
    function automatic logic signed [LANE_W-1:0] round_sat(input logic signed [LANE_W-1:0] x);
        logic signed [LANE_W:0] t;
        t = {x[LANE_W-1], x} + (LANE_W+1)'(1 << (COEFF_FRAC-1));
        t = t >>> COEFF_FRAC;
        if (t < 0)
            return '0;
        else if (t > PIX_MAX)
            return LANE_W'(PIX_MAX);
        else
            return LANE_W'(t);
    endfunction

    // Registered rounded lanes, frozen during a global stall.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            res_a <= '0;
            res_b <= '0;
        end else if (clken) begin
            res_a <= round_sat(raw_a);
            res_b <= round_sat(raw_b);
        end
    end
`else
    localparam int unused_coeff_frac = COEFF_FRAC;

    // Raw lanes pass straight through.
    always_comb begin
        res_a = raw_a;
        res_b = raw_b;
    end
`endif

endmodule

// File: rtl/dsp_simd2x_chain_ctrl.sv
// Drives a TAPS-deep cascade of 2-lane SIMD DSP stages and unpacks its result (macro BICUBIC_OUT_ROUND_SAT_EN: round/sat lanes).
// Latency: PIPE_LAT+1 cycles accept-to-out_valid (PIPE_LAT+2 with rounding); one word per cycle.
// Backpressure: out_valid & !out_ready drops dsp_clken, freezing the whole chain and deasserting in_ready.
module dsp_simd2x_chain_ctrl
    import bicubic_pkg::*;
#(
    parameter int TAPS        = 4,
    parameter int PIPE_LAT    = 7,
    parameter int INIT_CYCLES = 4,
    parameter int COEFF_FRAC  = 7
) (
    input  logic                        clk,
    input  logic                        areset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PIX_W*TAPS-1:0]       in_pix_a,
    input  logic [PIX_W*TAPS-1:0]       in_pix_b,
    input  logic [COEFF_W*TAPS-1:0]     in_coeff,
    input  logic                        flush_req,
    output logic                        flush_done,
    output logic                        dsp_clken,
    output logic                        dsp_reset,
    output logic [PIX_W*TAPS-1:0]       dsp_a,
    output logic [PIX_W*TAPS-1:0]       dsp_b,
    output logic [COEFF_W*TAPS-1:0]     dsp_coeff,
    input  logic [47:0]                 dsp_p,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [LANE_W-1:0]    out_res_a,
    output logic signed [LANE_W-1:0]    out_res_b
);

`ifdef BICUBIC_OUT_ROUND_SAT_EN
    localparam int VLEN = PIPE_LAT + 1;
`else
    localparam int VLEN = PIPE_LAT;
`endif
    localparam int CNT_W = $clog2(INIT_CYCLES + 1);

    state_t                   state;
    logic [CNT_W-1:0]         init_cnt;
    logic [VLEN-1:0]          vpipe;
    logic                     accept;
    tap_t                     tap_in  [TAPS];
    tap_t                     tap_drv [TAPS];
    logic signed [LANE_W-1:0] lane_a;
    logic signed [LANE_W-1:0] lane_b;
    logic                     unused_p_hi;

    assign dsp_clken   = ~(out_valid & ~out_ready);
    assign in_ready    = (state == ST_RUN) & dsp_clken;
    assign accept      = in_valid & in_ready;
    assign flush_done  = (state == ST_FLUSH) & (vpipe == '0) & dsp_clken;
    assign unused_p_hi = ^dsp_p[47:2*LANE_W];

    // Split the accepted word into taps; idle cycles inject zero bubbles.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            tap_in[k] = '0;
            if (accept) begin
                tap_in[k].pix_a = in_pix_a[PIX_W*k +: PIX_W];
                tap_in[k].pix_b = in_pix_b[PIX_W*k +: PIX_W];
                tap_in[k].coeff = in_coeff[COEFF_W*k +: COEFF_W];
            end
        end
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        if (k == 0) begin : g_direct
            assign tap_drv[k] = tap_in[k];
        end else begin : g_skew
            tap_t sr [k];

            // Delay tap k by k stall-aware cycles to meet the cascade wavefront.
            always_ff @(posedge clk or posedge areset) begin
                if (areset) begin
                    for (int i = 0; i < k; i++)
                        sr[i] <= '0;
                end else if (dsp_clken) begin
                    sr[0] <= tap_in[k];
                    for (int i = 1; i < k; i++)
                        sr[i] <= sr[i-1];
                end
            end

            assign tap_drv[k] = sr[k-1];
        end

        assign dsp_a[PIX_W*k +: PIX_W]       = tap_drv[k].pix_a;
        assign dsp_b[PIX_W*k +: PIX_W]       = tap_drv[k].pix_b;
        assign dsp_coeff[COEFF_W*k +: COEFF_W] = tap_drv[k].coeff;
    end

    // Sequencer: hold the DSPs in reset for INIT_CYCLES, then run/flush.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            dsp_reset <= 1'b1;
        end else if (dsp_clken) begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == CNT_W'(INIT_CYCLES - 1)) begin
                        state     <= ST_RUN;
                        dsp_reset <= 1'b0;
                    end else begin
                        init_cnt  <= init_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (flush_req)
                        state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (vpipe == '0)
                        state <= ST_RUN;
                end
                default: begin
                    state     <= ST_INIT;
                    dsp_reset <= 1'b1;
                end
            endcase
        end
    end

    // Track which cycles carry a real word through the DSP latency.
    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            vpipe <= '0;
        else if (dsp_clken)
            vpipe <= {vpipe[VLEN-2:0], accept};
    end

    dsp_lane_unpack #(
        .COEFF_FRAC (COEFF_FRAC)
    ) u_unpack (
`ifdef BICUBIC_OUT_ROUND_SAT_EN
        .clk    (clk),
        .areset (areset),
        .clken  (dsp_clken),
`endif
        .p      (dsp_p[2*LANE_W-1:0]),
        .res_a  (lane_a),
        .res_b  (lane_b)
    );

    // Output holding register; while valid, clken is high only if the sink takes it.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            out_valid <= 1'b0;
            out_res_a <= '0;
            out_res_b <= '0;
        end else if (dsp_clken) begin
            out_valid <= vpipe[VLEN-1];
            if (vpipe[VLEN-1]) begin
                out_res_a <= lane_a;
                out_res_b <= lane_b;
            end
        end
    end

endmodule

// File: tb/tb_dsp_simd2x_chain_ctrl.sv
module tb_dsp_simd2x_chain_ctrl;

    localparam int TAPS     = 4;
    localparam int PIPE_LAT = 7;
`ifdef BICUBIC_OUT_ROUND_SAT_EN
    localparam int EXP_LAT = PIPE_LAT + 2;
    localparam int E1A = 100,  E1B = 200;
    localparam int E2A = 0,    E2B = 0;
    localparam int E6A = 1,    E6B = 2;
`else
    localparam int EXP_LAT = PIPE_LAT + 1;
    localparam int E1A = 12800,  E1B = 25600;
    localparam int E2A = -65280, E2B = -256;
    localparam int E6A = 100,    E6B = 200;
`endif

    typedef struct { int a; int b; } exp_t;

    logic               clk, areset;
    logic               in_valid, in_ready;
    logic [8*TAPS-1:0]  in_pix_a, in_pix_b;
    logic [9*TAPS-1:0]  in_coeff;
    logic               flush_req, flush_done;
    logic               dsp_clken, dsp_reset;
    logic [8*TAPS-1:0]  dsp_a, dsp_b;
    logic [9*TAPS-1:0]  dsp_coeff;
    logic [47:0]        dsp_p;
    logic               out_valid, out_ready;
    logic signed [17:0] out_res_a, out_res_b;

    int   checks = 0;
    int   errors = 0;
    int   outs_seen = 0;
    bit   rdy_rand = 0;
    exp_t q[$];

    dsp_simd2x_chain_ctrl dut (
        .clk        (clk),
        .areset     (areset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pix_a   (in_pix_a),
        .in_pix_b   (in_pix_b),
        .in_coeff   (in_coeff),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .dsp_clken  (dsp_clken),
        .dsp_reset  (dsp_reset),
        .dsp_a      (dsp_a),
        .dsp_b      (dsp_b),
        .dsp_coeff  (dsp_coeff),
        .dsp_p      (dsp_p),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res_a  (out_res_a),
        .out_res_b  (out_res_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural cascade of TAPS SIMD DSP stages, PIPE_LAT deep.
    logic signed [47:0] m_acc [TAPS];
    logic signed [47:0] m_dly [PIPE_LAT-TAPS];

    function automatic logic signed [47:0] simd_mul(input logic [7:0] a, input logic [7:0] b,
                                                    input logic [8:0] c);
        logic signed [47:0] sc, pa, pb;
        sc = {{39{c[8]}}, c};
        pa = $signed({40'd0, a}) * sc;
        pb = $signed({40'd0, b}) * sc;
        return pa + (pb <<< 18);
    endfunction

    always @(posedge clk) begin
        if (dsp_reset) begin
            for (int k = 0; k < TAPS; k++) m_acc[k] <= '0;
            for (int j = 0; j < PIPE_LAT-TAPS; j++) m_dly[j] <= '0;
        end else if (dsp_clken) begin
            m_acc[0] <= simd_mul(dsp_a[7:0], dsp_b[7:0], dsp_coeff[8:0]);
            for (int k = 1; k < TAPS; k++)
                m_acc[k] <= m_acc[k-1] + simd_mul(dsp_a[8*k +: 8], dsp_b[8*k +: 8], dsp_coeff[9*k +: 9]);
            m_dly[0] <= m_acc[TAPS-1];
            for (int j = 1; j < PIPE_LAT-TAPS; j++) m_dly[j] <= m_dly[j-1];
        end
    end
    assign dsp_p = m_dly[PIPE_LAT-TAPS-1];

    function automatic logic [31:0] pk8(input int v3, input int v2, input int v1, input int v0);
        return {v3[7:0], v2[7:0], v1[7:0], v0[7:0]};
    endfunction

    function automatic logic [35:0] pk9(input int v3, input int v2, input int v1, input int v0);
        return {v3[8:0], v2[8:0], v1[8:0], v0[8:0]};
    endfunction

    function automatic int rsat(input int x);
        int t;
        t = (x + 64) >>> 7;
        if (t < 0) t = 0;
        if (t > 255) t = 255;
        return t;
    endfunction

    // Reference dot product per lane (inputs kept small enough not to overflow 18 bits).
    function automatic exp_t golden(input logic [31:0] pa, input logic [31:0] pb, input logic [35:0] pc);
        exp_t r;
        int sa, sb;
        sa = 0;
        sb = 0;
        for (int k = 0; k < TAPS; k++) begin
            sa += int'(pa[8*k +: 8]) * int'($signed(pc[9*k +: 9]));
            sb += int'(pb[8*k +: 8]) * int'($signed(pc[9*k +: 9]));
        end
`ifdef BICUBIC_OUT_ROUND_SAT_EN
        r.a = rsat(sa);
        r.b = rsat(sb);
`else
        r.a = sa;
        r.b = sb;
`endif
        return r;
    endfunction

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Present one word; called and returns at posedge+1.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [35:0] c,
                        input bit push, input exp_t e);
        bit ok = 0;
        in_pix_a = a;
        in_pix_b = b;
        in_coeff = c;
        in_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready %0d expected 1", in_ready);
        end else if (push) begin
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) break;
        end
        chk("drain_left", q.size(), 0);
    endtask

    // Output monitor: every handshake pops and compares one expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got a=%0d b=%0d expected none", out_res_a, out_res_b);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("res_a", out_res_a, e.a);
                    chk("res_b", out_res_b, e.b);
                end
                outs_seen++;
            end
        end
    end

    // Sink readiness: always ready, or a coin flip each cycle.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int rcnt, lat, base, pulses;
        bit flag;
        logic [31:0] ra, rb;
        logic [35:0] rc;

        areset = 1'b1; in_valid = 1'b0; flush_req = 1'b0;
        in_pix_a = '0; in_pix_b = '0; in_coeff = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_dsp_reset", dsp_reset, 1);
        chk("rst_dsp_clken", dsp_clken, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_res_a", out_res_a, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_dsp_a", dsp_a, 0);

        // INIT length and in_ready rise
        areset = 1'b0;
        rcnt = 0;
        flag = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dsp_reset !== 1'b1) break;
            rcnt++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) flag = 1;
        end
        chk("init_len", rcnt, 4);
        chk("init_rdy_ov", flag, 0);
        chk("in_ready_c5", in_ready, 1);
        flag = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) flag = 1;
        end
        chk("idle_out_valid", flag, 0);
        @(posedge clk);
        #1;

        // Symmetric kernel, latency measured
        e.a = E1A; e.b = E1B;
        send(pk8(100, 100, 100, 100), pk8(200, 200, 200, 200), pk9(-9, 73, 73, -9), 1, e);
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
            lat++;
        end
        chk("latency", lat, EXP_LAT);
        @(posedge clk);
        #1;
        wait_drain();

        // Negative lane A borrows from lane B
        e.a = E2A; e.b = E2B;
        send(pk8(255, 0, 0, 0), pk8(1, 0, 0, 0), pk9(-256, 0, 0, 0), 1, e);
        wait_drain();

        // 32 back-to-back words under random backpressure
        rdy_rand = 1;
        base = outs_seen;
        for (int n = 0; n < 32; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = pk9(int'($urandom_range(0, 127)) - 64, int'($urandom_range(0, 127)) - 64,
                     int'($urandom_range(0, 127)) - 64, int'($urandom_range(0, 127)) - 64);
            send(ra, rb, rc, 1, golden(ra, rb, rc));
        end
        wait_drain();
        rdy_rand = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_count", outs_seen - base, 32);

        // Flush with three words in flight
        base = outs_seen;
        for (int n = 0; n < 3; n++) begin
            ra = pk8(n + 1, 2, 3, 4);
            rb = pk8(5, n + 6, 7, 8);
            rc = pk9(10, -20, 30, n - 5);
            send(ra, rb, rc, 1, golden(ra, rb, rc));
        end
        flush_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (flush_done === 1'b1) begin
                pulses++;
                flush_req = 1'b0;
            end
            @(negedge clk);
        end
        flush_req = 1'b0;
        chk("flush_pulses", pulses, 1);
        chk("flush_outs", outs_seen - base, 3);
        chk("flush_back_run", in_ready, 1);
        @(posedge clk);
        #1;

        // Flush with an empty pipeline completes on the first FLUSH cycle
        flush_req = 1'b1;
        @(negedge clk);
        chk("idle_flush_run", flush_done, 0);
        @(negedge clk);
        chk("idle_flush_done", flush_done, 1);
        flush_req = 1'b0;
        @(negedge clk);
        chk("idle_flush_after", flush_done, 0);
        chk("idle_flush_rdy", in_ready, 1);
        @(posedge clk);
        #1;

        // Reset with five words in flight
        for (int n = 0; n < 5; n++)
            send(pk8(50, 60, 70, 80), pk8(9, 9, 9, 9), pk9(1, 1, 1, 1), 0, e);
        areset = 1'b1;
        @(negedge clk);
        chk("rst_mid_ov", out_valid, 0);
        @(posedge clk);
        #1;
        areset = 1'b0;
        flag = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid !== 1'b0) flag = 1;
        end
        chk("no_stale_out", flag, 0);
        @(posedge clk);
        #1;
        e.a = E6A; e.b = E6B;
        send(pk8(10, 10, 10, 10), pk8(20, 20, 20, 20), pk9(4, 3, 2, 1), 1, e);
        wait_drain();
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
